lockstep_fifo: RTL and testbench
================================

Name: lockstep_fifo

Overview:
- Single-clock first-word-fall-through FIFO buffering DSIZE-bit flits between NoC router stages.
- Port names and semantics mirror the dual-clock async_fifo: wdata/winc/wfull on the write side, rdata/rinc/rempty on the read side.
- Depth is 2**ADDRSIZE.
- Write and read sides share one clock, so there are no pointer synchronisers.

Parameters:
- DSIZE, 32, data word width in bits.
- ADDRSIZE, 5, address width; depth is 2**ADDRSIZE (32 entries).

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- wdata  input  DSIZE  write data, sampled on the clk edge when a write is accepted.
- winc  input  1  write request; level-sampled every edge; one word per edge while high and not full.
- wfull  output  1  FIFO holds 2**ADDRSIZE words.
- rinc  input  1  read/pop request; level-sampled every edge.
- rdata  output  DSIZE  head-of-queue word (combinational from memory at the read address).
- rempty  output  1  FIFO holds zero words.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- State:
  - wptr and rptr, each ADDRSIZE+1 bits, binary.
  - memory mem[0 .. 2**ADDRSIZE-1]. Memory is not reset.
- Reset (rst=1 at an edge): wptr=0, rptr=0. rst has priority over winc/rinc at that edge.
- Flags are combinational from the registered pointers:
  - rempty = (wptr == rptr).
  - wfull = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) and (low ADDRSIZE bits equal).
  - After reset: rempty=1, wfull=0.
- Write accept: winc && !wfull at the edge -> mem[wptr[ADDRSIZE-1:0]] <= wdata; wptr <= wptr+1.
- Read accept: rinc && !rempty at the edge -> rptr <= rptr+1.
- rdata = mem[rptr[ADDRSIZE-1:0]], zero-latency show-ahead.
  - rdata is valid whenever rempty=0.
  - rdata is don't-care while rempty=1; the value is unspecified, not X-forced.
- Latency: a word written at edge N is visible on rdata, with rempty=0, immediately after edge N.
- Overflow: winc while wfull is ignored. Memory and wptr are unchanged; no error flag.
- Underflow: rinc while rempty is ignored. rptr is unchanged.
- Simultaneous winc and rinc:
  - Each is qualified by the flags sampled before the edge.
  - Not full and not empty: both accepted; occupancy unchanged.
  - Empty: only the write is accepted; rempty deasserts.
  - Full: only the read is accepted; wfull deasserts.
- Wrap-around: pointers wrap modulo 2**(ADDRSIZE+1). The MSB distinguishes full from empty. Memory addressing uses the low ADDRSIZE bits.
- Reset mid-operation: contents are discarded logically (pointers zeroed, rempty=1). Memory contents are retained but unreachable.
- Held inputs: a winc held high for k edges writes k words (the same wdata if wdata is held). The producer must drop winc to avoid duplicate writes.

Decomposition:
- Shared package noc_fifo_pkg:
  - default DSIZE and ADDRSIZE;
  - function/constant DEPTH = 2**ADDRSIZE;
  - pointer width PTRW = ADDRSIZE+1.
- One sub-module, fifo_mem:
  - dual-port RAM; synchronous write (wclken, waddr, wdata), asynchronous read (raddr -> rdata);
  - no reset.
- The pointer/flag logic stays in lockstep_fifo.

Test Plan:
- Reset then single write:
  - Stimulus: rst=1 for 2 edges; release; winc=1 for one edge with wdata=32'h0000BBBB.
  - Response: rempty=1, wfull=0 during reset; after the edge rempty=0, rdata=32'h0000BBBB, wfull=0.
- Back-to-back writes then drain:
  - Stimulus: write 32'h00010001 twice; then rinc=1 for 3 edges.
  - Response: rdata sequence 0000BBBB, 00010001, 00010001; rempty=1 after the third pop.
- Simultaneous read/write:
  - Stimulus: with 1 word (0000BBBB) queued, winc=rinc=1 with wdata=32'h0100CCCC for one edge.
  - Response: occupancy stays 1; rdata=32'h0100CCCC; rempty=0.
- Empty read plus write:
  - Stimulus: from empty, rinc=1 alone.
  - Response: no change, rempty stays 1.
  - Stimulus: then winc=rinc=1 with wdata=32'hA5A5A5A5.
  - Response: only the write is accepted; rempty=0, rdata=32'hA5A5A5A5.
- Full and overflow, then wrap:
  - Stimulus: write 32 words 0..31.
  - Response: wfull=1 after the 32nd.
  - Stimulus: a 33rd write (value 99).
  - Response: ignored.
  - Stimulus: read all.
  - Response: 0..31 in order; wfull drops after the first pop; rempty=1 at the end.
  - Stimulus: repeat 3 times.
  - Response: pointers wrap, order preserved.
- Reset mid-stream:
  - Stimulus: with 5 words queued, assert rst for one edge with winc=rinc=1.
  - Response: rempty=1, wfull=0, no write captured.
  - Stimulus: next write 32'h12345678.
  - Response: rdata=32'h12345678.

Source files
------------

// File: rtl/noc_fifo_pkg.sv
// noc_fifo_pkg -- shared sizing for the NoC flit FIFOs.
//   DSIZE_DEF    : default flit width in bits
//   ADDRSIZE_DEF : default address width (depth = 2**ADDRSIZE)
//   depth_of()   : entries for a given address width
//   DEPTH, PTRW  : default depth and pointer width (one extra MSB for wrap)
package noc_fifo_pkg;
    localparam int DSIZE_DEF    = 32;
    localparam int ADDRSIZE_DEF = 5;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEPTH = depth_of(ADDRSIZE_DEF);
    localparam int PTRW  = ADDRSIZE_DEF + 1;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem -- dual-port storage for lockstep_fifo.
//   clk    : write clock
//   wclken : write enable, captures wdata at waddr on the rising edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : asynchronous read data at raddr
// No reset: contents are only reachable through the FIFO pointers.
module fifo_mem
    import noc_fifo_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                clk,
    input  logic                wclken,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DSIZE-1:0]    wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DSIZE-1:0]    rdata
);
    logic [DSIZE-1:0] mem [depth_of(ADDRSIZE)];

    always_ff @(posedge clk) begin
        if (wclken)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/lockstep_fifo.sv
// lockstep_fifo -- single-clock first-word-fall-through flit FIFO.
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset (pointers only)
//   wdata  : write data, captured when a write is accepted
//   winc   : write request, one word per edge while high and not full
//   wfull  : FIFO holds 2**ADDRSIZE words
//   rinc   : pop request, one word per edge while high and not empty
//   rdata  : head-of-queue word, valid whenever rempty is low
//   rempty : FIFO holds zero words
module lockstep_fifo
    import noc_fifo_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
);
    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wptr, rptr;
    logic          wen, ren;

    // Pointers carry one extra MSB so equal addresses can be told apart:
    // same lap means empty, different lap means full.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                    (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);

    // Qualified against the flags from before the edge, so a push into an
    // empty FIFO or a pop from a full one is handled without a bypass path.
    assign wen = winc && !wfull;
    assign ren = rinc && !rempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wen) wptr <= wptr + PW'(1);
            if (ren) rptr <= rptr + PW'(1);
        end
    end

    // A reset write is blocked too, so nothing stale lands in memory.
    fifo_mem #(
        .DSIZE    (DSIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk    (clk),
        .wclken (wen && !rst),
        .waddr  (wptr[ADDRSIZE-1:0]),
        .wdata  (wdata),
        .raddr  (rptr[ADDRSIZE-1:0]),
        .rdata  (rdata)
    );
endmodule

// File: tb/tb_lockstep_fifo.sv
module tb_lockstep_fifo;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic [DW-1:0] rdata;
    logic          wfull, rempty;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    logic [DW-1:0] q[$];

    lockstep_fifo #(.DSIZE(DW), .ADDRSIZE(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .winc   (winc),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Queue model: occupancy decides the flags, head of queue is rdata.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            bit do_w, do_r;
            do_w = winc && (q.size() < DEPTH);
            do_r = rinc && (q.size() > 0);
            if (do_r) void'(q.pop_front());
            if (do_w) q.push_back(wdata);
        end
        if (rst) cmp_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rempty_model", {31'b0, rempty}, {31'b0, q.size() == 0});
            chk("wfull_model",  {31'b0, wfull},  {31'b0, q.size() == DEPTH});
            if (q.size() > 0) chk("rdata_model", rdata, q[0]);
        end
    end

    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        rst = r; winc = w; rinc = rd; wdata = d;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    endtask

    initial begin
        // reset for two edges
        step(1, 0, 0, '0);
        chk("rst_rempty", {31'b0, rempty}, 32'd1);
        chk("rst_wfull",  {31'b0, wfull},  32'd0);
        step(1, 0, 0, '0);
        chk("rst2_rempty", {31'b0, rempty}, 32'd1);

        // single write, zero-latency show-ahead
        step(0, 1, 0, 32'h0000BBBB);
        chk("w1_rdata",  rdata, 32'h0000BBBB);
        chk("w1_rempty", {31'b0, rempty}, 32'd0);
        chk("w1_wfull",  {31'b0, wfull},  32'd0);

        // back-to-back writes then drain
        step(0, 1, 0, 32'h00010001);
        step(0, 1, 0, 32'h00010001);
        chk("drain0", rdata, 32'h0000BBBB);
        step(0, 0, 1, '0);
        chk("drain1", rdata, 32'h00010001);
        step(0, 0, 1, '0);
        chk("drain2", rdata, 32'h00010001);
        step(0, 0, 1, '0);
        chk("drain_empty", {31'b0, rempty}, 32'd1);

        // simultaneous read/write with one word queued
        step(0, 1, 0, 32'h0000BBBB);
        step(0, 1, 1, 32'h0100CCCC);
        chk("rw_rdata",  rdata, 32'h0100CCCC);
        chk("rw_rempty", {31'b0, rempty}, 32'd0);
        step(0, 0, 1, '0);
        chk("rw_drained", {31'b0, rempty}, 32'd1);

        // underflow, then read+write on empty
        step(0, 0, 1, '0);
        chk("uf_rempty", {31'b0, rempty}, 32'd1);
        step(0, 1, 1, 32'hA5A5A5A5);
        chk("er_rdata",  rdata, 32'hA5A5A5A5);
        chk("er_rempty", {31'b0, rempty}, 32'd0);
        step(0, 0, 1, '0);

        // fill, overflow, drain; three laps to exercise pointer wrap
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DW'(lap * 32 + i));
            chk("full_wfull", {31'b0, wfull}, 32'd1);
            step(0, 1, 0, 32'd99);
            chk("ovf_wfull", {31'b0, wfull}, 32'd1);
            chk("ovf_head",  rdata, DW'(lap * 32));
            for (int i = 0; i < DEPTH; i++) begin
                chk("lap_order", rdata, DW'(lap * 32 + i));
                step(0, 0, 1, '0);
                if (i == 0) chk("pop_wfull", {31'b0, wfull}, 32'd0);
            end
            chk("lap_empty", {31'b0, rempty}, 32'd1);
        end

        // full + simultaneous read/write: only the read goes through
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DW'(i + 200));
        step(0, 1, 1, 32'hDEADBEEF);
        chk("frw_wfull", {31'b0, wfull}, 32'd0);
        chk("frw_rdata", rdata, 32'd201);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, '0);
        chk("frw_empty", {31'b0, rempty}, 32'd1);

        // reset mid-stream with winc/rinc also high
        for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(i + 300));
        step(1, 1, 1, 32'hFEEDF00D);
        chk("mrst_rempty", {31'b0, rempty}, 32'd1);
        chk("mrst_wfull",  {31'b0, wfull},  32'd0);
        step(0, 1, 0, 32'h12345678);
        chk("mrst_rdata", rdata, 32'h12345678);
        step(0, 0, 1, '0);
        chk("mrst_empty", {31'b0, rempty}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
